// File: rtl/vga_scan_scheduler.sv
// ============================================================================
// vga_scan_scheduler
//
// Master timing and sequencing controller for the parallax VGA pipeline.
// Generates the scan raster (default 832x520 total, 640x480 visible), the
// sync/enable decode, line and frame strobes, and owns the per-layer
// horizontal scroll offsets consumed by the parallax layer datapath.
//
// Optional feature macro: VGA_SCROLL_EN
//   defined   : scroll scheduler and frame counter present; both advance once
//               per frame on the frame_start cycle unless freeze is high.
//   undefined : scroll_offsets and frame_count are tied to zero and freeze is
//               ignored. Timing outputs are identical in both builds.
//
// Ports:
//   clk            in   pixel clock
//   reset          in   asynchronous, active-low reset
//   freeze         in   holds scroll offsets / frame_count at frame boundary
//   hsync          out  horizontal sync, active low
//   vsync          out  vertical sync, active low (whole line incl. h-blank)
//   display_on     out  1 inside the visible window
//   x, y           out  current horizontal / vertical counter values
//   line_start     out  1-cycle pulse when x == 0
//   frame_start    out  1-cycle pulse at x == 0, y == V_VISIBLE
//   frame_count    out  frames completed (wraps at 16 bits)
//   scroll_offsets out  layer i at bits [i*SCROLL_W +: SCROLL_W]
// ============================================================================
module vga_scan_scheduler #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 24,
    parameter int unsigned H_SYNC    = 64,
    parameter int unsigned H_BACK    = 104,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 9,
    parameter int unsigned V_SYNC    = 3,
    parameter int unsigned V_BACK    = 28,
    parameter int unsigned LAYERS    = 4,
    parameter int unsigned SCROLL_W  = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         freeze,
    output logic                         hsync,
    output logic                         vsync,
    output logic                         display_on,
    output logic [9:0]                   x,
    output logic [9:0]                   y,
    output logic                         line_start,
    output logic                         frame_start,
    output logic [15:0]                  frame_count,
    output logic [LAYERS*SCROLL_W-1:0]   scroll_offsets
);

    // ------------------------------------------------------------------
    // Raster geometry
    // ------------------------------------------------------------------
    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
    localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);

    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
    localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    // ------------------------------------------------------------------
    // Scan counters
    // ------------------------------------------------------------------
    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;

    always_comb begin
        h_d = h_q + 10'd1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            if (v_q == V_LAST) begin
                v_d = '0;
            end else begin
                v_d = v_q + 10'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output decode from next-state counters, so the registered outputs
    // line up with the registered counter values in the same cycle.
    // ------------------------------------------------------------------
    logic hsync_q,       hsync_d;
    logic vsync_q,       vsync_d;
    logic display_on_q,  display_on_d;
    logic line_start_q,  line_start_d;
    logic frame_start_q, frame_start_d;

    always_comb begin
        hsync_d       = !((h_d >= HS_START) && (h_d < HS_END));
        vsync_d       = !((v_d >= VS_START) && (v_d < VS_END));
        display_on_d  = (h_d < H_VIS_END) && (v_d < V_VIS_END);
        line_start_d  = (h_d == '0);
        frame_start_d = (h_d == '0) && (v_d == V_VIS_END);
    end

    // Reset parks the raster at the first blank line with no strobes; the
    // first pulses appear only when the counters naturally reach them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_q           <= '0;
            v_q           <= V_VIS_END;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            display_on_q  <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            display_on_q  <= display_on_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign display_on  = display_on_q;
    assign x           = h_q;
    assign y           = v_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

    // ------------------------------------------------------------------
    // Scroll scheduler
    // ------------------------------------------------------------------
`ifdef VGA_SCROLL_EN
    logic [SCROLL_W-1:0] off_q [LAYERS];
    logic [SCROLL_W-1:0] off_d [LAYERS];
    logic [15:0]         fc_q, fc_d;

    // Update lands on the edge that ends the frame_start cycle, i.e. at the
    // top of vertical blanking, so offsets never move inside the visible area.
    always_comb begin
        fc_d = fc_q;
        for (int unsigned i = 0; i < LAYERS; i++) begin
            off_d[i] = off_q[i];
        end
        if (frame_start_q && !freeze) begin
            fc_d = fc_q + 16'd1;
            for (int unsigned i = 0; i < LAYERS; i++) begin
                off_d[i] = off_q[i] + SCROLL_W'(i + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fc_q <= '0;
            for (int unsigned i = 0; i < LAYERS; i++) begin
                off_q[i] <= '0;
            end
        end else begin
            fc_q <= fc_d;
            for (int unsigned i = 0; i < LAYERS; i++) begin
                off_q[i] <= off_d[i];
            end
        end
    end

    assign frame_count = fc_q;

    for (genvar g = 0; g < LAYERS; g++) begin : g_pack
        assign scroll_offsets[g*SCROLL_W +: SCROLL_W] = off_q[g];
    end
`else
    logic unused_freeze;

    assign unused_freeze  = freeze;
    assign frame_count    = '0;
    assign scroll_offsets = '0;
`endif

endmodule

// File: tb/tb_vga_scan_scheduler.sv
module tb_vga_scan_scheduler;

    // Reduced raster so whole frames fit in a short run; rules are unchanged.
    localparam int HV = 16;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 5;
    localparam int VV = 6;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int NL = 4;
    localparam int SW = 5;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FT = HT * VT;

`ifdef VGA_SCROLL_EN
    localparam bit SCROLL_ON = 1'b1;
`else
    localparam bit SCROLL_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              freeze = 1'b0;
    logic              hsync, vsync, display_on;
    logic [9:0]        x, y;
    logic              line_start, frame_start;
    logic [15:0]       frame_count;
    logic [NL*SW-1:0]  scroll_offsets;

    vga_scan_scheduler #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .LAYERS(NL), .SCROLL_W(SW)
    ) dut (
        .clk(clk), .reset(reset), .freeze(freeze),
        .hsync(hsync), .vsync(vsync), .display_on(display_on),
        .x(x), .y(y), .line_start(line_start), .frame_start(frame_start),
        .frame_count(frame_count), .scroll_offsets(scroll_offsets)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    // Reference model: t = clock edges since reset release; raster position
    // is a linear index into the frame starting at the first blank line.
    int t;
    int exp_fc;
    int exp_off [NL];

    function automatic int hpos(input int tt);
        return ((VV * HT + tt) % FT) % HT;
    endfunction

    function automatic int vpos(input int tt);
        return ((VV * HT + tt) % FT) / HT;
    endfunction

    function automatic bit model_fs(input int tt);
        return (tt > 0) && (hpos(tt) == 0) && (vpos(tt) == VV);
    endfunction

    function automatic logic [NL*SW-1:0] model_offv();
        logic [NL*SW-1:0] v;
        v = '0;
        for (int i = 0; i < NL; i++) v[i*SW +: SW] = SW'(exp_off[i]);
        return v;
    endfunction

    task automatic model_reset();
        t = 0;
        exp_fc = 0;
        for (int i = 0; i < NL; i++) exp_off[i] = 0;
    endtask

    // One clock with the given freeze level; model advances alongside.
    task automatic tick(input bit fr);
        freeze = fr;
        @(posedge clk);
        if (SCROLL_ON && !fr && model_fs(t)) begin
            exp_fc = (exp_fc + 1) % 65536;
            for (int i = 0; i < NL; i++) exp_off[i] = (exp_off[i] + i + 1) % (1 << SW);
        end
        t++;
        #1;
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b0;
        freeze = 1'b0;
        model_reset();
        repeat (50) @(posedge clk);
        #1;
        compared++;
        if ({hsync, vsync, display_on} !== 3'b110) begin
            mismatched++;
            $display("FAIL reset_sync: got hs/vs/de=%b%b%b expected 110", hsync, vsync, display_on);
        end
        compared++;
        if (int'(y) !== VV || int'(x) !== 0) begin
            mismatched++;
            $display("FAIL reset_xy: got x=%0d y=%0d expected x=0 y=%0d", x, y, VV);
        end
        compared++;
        if ({line_start, frame_start} !== 2'b00 || frame_count !== 16'd0 || scroll_offsets !== '0) begin
            mismatched++;
            $display("FAIL reset_misc: got ls=%b fs=%b fc=%0d off=%h expected 0", line_start, frame_start, frame_count, scroll_offsets);
        end
        reset = 1'b1;
        tick(1'b0);
        compared++;
        if (int'(x) !== 1 || int'(y) !== VV || line_start !== 1'b0 || frame_start !== 1'b0) begin
            mismatched++;
            $display("FAIL first_edge: got x=%0d y=%0d ls=%b fs=%b expected x=1 y=%0d no pulses", x, y, line_start, frame_start, VV);
        end
        n = 1;
        while (hsync !== 1'b0 && n < 4 * HT) begin
            tick(1'b0);
            n++;
        end
        compared++;
        if (n !== HV + HF) begin
            mismatched++;
            $display("FAIL first_hsync_fall: got %0d clocks expected %0d", n, HV + HF);
        end
    endtask

    task automatic test_line();
        int n, low;
        n = 0;
        while (line_start !== 1'b1 && n < 2 * HT) begin
            tick(1'($urandom_range(0, 1)));
            n++;
        end
        low = 0;
        n = 0;
        do begin
            if (hsync === 1'b0) low++;
            tick(1'($urandom_range(0, 1)));
            n++;
        end while (line_start !== 1'b1 && n < 2 * HT);
        compared++;
        if (n !== HT) begin
            mismatched++;
            $display("FAIL line_period: got %0d expected %0d", n, HT);
        end
        compared++;
        if (low !== HS) begin
            mismatched++;
            $display("FAIL hsync_width: got %0d expected %0d", low, HS);
        end
    endtask

    task automatic test_frame();
        int n, de, vlow, falls, back_lines, vis_lines;
        bit seen_vs;
        logic prev_hs;
        n = 0;
        while (frame_start !== 1'b1 && n < 2 * FT) begin
            tick(1'($urandom_range(0, 1)));
            n++;
        end
        de = 0; vlow = 0; falls = 0; back_lines = 0; vis_lines = 0;
        seen_vs = 1'b0;
        prev_hs = hsync;
        n = 0;
        do begin
            if (display_on === 1'b1) de++;
            if (vsync === 1'b0) begin
                vlow++;
                seen_vs = 1'b1;
            end
            if (!seen_vs && prev_hs === 1'b1 && hsync === 1'b0) falls++;
            prev_hs = hsync;
            if (seen_vs && vsync === 1'b1 && display_on === 1'b0 && line_start === 1'b1) back_lines++;
            if (display_on === 1'b1 && line_start === 1'b1) vis_lines++;
            tick(1'($urandom_range(0, 1)));
            n++;
        end while (frame_start !== 1'b1 && n < 2 * FT);
        compared++;
        if (n !== FT) begin
            mismatched++;
            $display("FAIL frame_period: got %0d expected %0d", n, FT);
        end
        compared++;
        if (de !== HV * VV) begin
            mismatched++;
            $display("FAIL display_cycles: got %0d expected %0d", de, HV * VV);
        end
        compared++;
        if (vlow !== VS * HT) begin
            mismatched++;
            $display("FAIL vsync_width: got %0d expected %0d", vlow, VS * HT);
        end
        compared++;
        if (falls !== VF) begin
            mismatched++;
            $display("FAIL hsync_before_vsync: got %0d expected %0d", falls, VF);
        end
        compared++;
        if (back_lines !== VB || vis_lines !== VV) begin
            mismatched++;
            $display("FAIL line_counts: got back=%0d vis=%0d expected back=%0d vis=%0d", back_lines, vis_lines, VB, VV);
        end
    endtask

    task automatic test_random_model();
        int h, v;
        bit e_hs, e_vs, e_de, e_ls, e_fs;
        for (int c = 0; c < 2 * FT + 37; c++) begin
            tick(1'($urandom_range(0, 1)));
            h = hpos(t);
            v = vpos(t);
            e_hs = !(h >= HV + HF && h < HV + HF + HS);
            e_vs = !(v >= VV + VF && v < VV + VF + VS);
            e_de = (h < HV) && (v < VV);
            e_ls = (h == 0);
            e_fs = model_fs(t);
            compared++;
            if ({hsync, vsync, display_on, line_start, frame_start} !== {e_hs, e_vs, e_de, e_ls, e_fs}) begin
                mismatched++;
                $display("FAIL model_timing t=%0d: got hs/vs/de/ls/fs=%b%b%b%b%b expected %b%b%b%b%b",
                         t, hsync, vsync, display_on, line_start, frame_start, e_hs, e_vs, e_de, e_ls, e_fs);
            end
            compared++;
            if (int'(x) !== h || int'(y) !== v) begin
                mismatched++;
                $display("FAIL model_xy t=%0d: got x=%0d y=%0d expected x=%0d y=%0d", t, x, y, h, v);
            end
            compared++;
            if (int'(frame_count) !== exp_fc || scroll_offsets !== model_offv()) begin
                mismatched++;
                $display("FAIL model_scroll t=%0d: got fc=%0d off=%h expected fc=%0d off=%h",
                         t, frame_count, scroll_offsets, exp_fc, model_offv());
            end
        end
    endtask

    task automatic test_scroll();
        int fs_seen, idx, n, unfrozen;
        logic [NL*SW-1:0] e_off;
        reset = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        fs_seen = 0;
        n = 0;
        while (fs_seen < 24 && n < 26 * FT) begin
            if (frame_start === 1'b1) begin
                idx = fs_seen;
                fs_seen++;
                tick(idx == 3 || idx == 4);
                if (fs_seen == 3 || fs_seen == 5 || fs_seen == 24) begin
                    unfrozen = (fs_seen >= 5) ? fs_seen - 2 : fs_seen;
                    e_off = '0;
                    if (SCROLL_ON)
                        for (int i = 0; i < NL; i++) e_off[i*SW +: SW] = SW'(((i + 1) * unfrozen) % (1 << SW));
                    compared++;
                    if (int'(frame_count) !== (SCROLL_ON ? unfrozen : 0)) begin
                        mismatched++;
                        $display("FAIL scroll_fc after %0d frames: got %0d expected %0d",
                                 fs_seen, frame_count, SCROLL_ON ? unfrozen : 0);
                    end
                    compared++;
                    if (scroll_offsets !== e_off) begin
                        mismatched++;
                        $display("FAIL scroll_offsets after %0d frames: got %h expected %h", fs_seen, scroll_offsets, e_off);
                    end
                end
            end else begin
                tick(1'($urandom_range(0, 1)));
            end
            n++;
        end
        compared++;
        if (fs_seen !== 24) begin
            mismatched++;
            $display("FAIL scroll_frames_seen: got %0d expected 24", fs_seen);
        end
    endtask

    task automatic test_reset_midsync();
        int n;
        n = 0;
        while (!(hpos(t) == HV + HF + 1 && vpos(t) == VV + VF + 1) && n < 2 * FT) begin
            tick(1'($urandom_range(0, 1)));
            n++;
        end
        compared++;
        if ({hsync, vsync} !== 2'b00) begin
            mismatched++;
            $display("FAIL midsync_pre: got hs/vs=%b%b expected 00", hsync, vsync);
        end
        #2;
        reset = 1'b0;
        #1;
        compared++;
        if ({hsync, vsync, display_on} !== 3'b110 || int'(x) !== 0 || int'(y) !== VV) begin
            mismatched++;
            $display("FAIL midsync_async: got hs/vs/de=%b%b%b x=%0d y=%0d expected 110 x=0 y=%0d",
                     hsync, vsync, display_on, x, y, VV);
        end
        compared++;
        if (frame_count !== 16'd0 || scroll_offsets !== '0 || {line_start, frame_start} !== 2'b00) begin
            mismatched++;
            $display("FAIL midsync_clear: got fc=%0d off=%h ls=%b fs=%b expected zeros", frame_count, scroll_offsets, line_start, frame_start);
        end
        model_reset();
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        tick(1'b0);
        compared++;
        if (int'(x) !== 1 || int'(y) !== VV || line_start !== 1'b0 || frame_start !== 1'b0) begin
            mismatched++;
            $display("FAIL midsync_restart: got x=%0d y=%0d ls=%b fs=%b expected x=1 y=%0d no pulses", x, y, line_start, frame_start, VV);
        end
        n = 1;
        while (hsync !== 1'b0 && n < 4 * HT) begin
            tick(1'b0);
            n++;
        end
        compared++;
        if (n !== HV + HF) begin
            mismatched++;
            $display("FAIL midsync_hsync_fall: got %0d clocks expected %0d", n, HV + HF);
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_random_model();
        test_scroll();
        test_reset_midsync();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/vga_scan_scheduler.md
Name: vga_scan_scheduler

Overview:
- Master timing and sequencing controller for the parallax VGA pipeline.
- Generates 832x520 scan timing: 640x480 visible, hsync/vsync, display enable and pixel coordinates.
- Issues line and frame strobes.
- Owns the per-layer horizontal scroll offsets that the parallax layer datapath consumes, advancing them once per frame at the start of vertical blanking.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 24, horizontal front porch clocks
- H_SYNC, 64, hsync low width in clocks
- H_BACK, 104, horizontal back porch clocks (line total 832)
- V_VISIBLE, 480, active lines
- V_FRONT, 9, vertical front porch lines
- V_SYNC, 3, vsync low width in lines
- V_BACK, 28, vertical back porch lines (frame total 520)
- LAYERS, 4, number of parallax layers with scroll offsets
- SCROLL_W, 10, width of each scroll offset

Ports:
- clk  input  1  pixel clock
- reset  input  1  asynchronous, active-low reset
- freeze  input  1  when 1, scroll offsets and frame_count hold at frame boundaries
- hsync  output  1  horizontal sync, active low
- vsync  output  1  vertical sync, active low
- display_on  output  1  1 inside the visible window
- x  output  10  current h_cnt
- y  output  10  current v_cnt
- line_start  output  1  1-cycle pulse when h_cnt==0
- frame_start  output  1  1-cycle pulse at h_cnt==0, v_cnt==V_VISIBLE (first blank line)
- frame_count  output  16  frames completed
- scroll_offsets  output  LAYERS*SCROLL_W  layer i occupies bits [i*SCROLL_W +: SCROLL_W]

Behaviour:
- Counters:
  - h_cnt runs 0..831 and wraps to 0.
  - v_cnt increments when h_cnt wraps; it runs 0..519 and wraps to 0.
- Horizontal regions: visible h 0..639; front porch 640..663; sync 664..727; back porch 728..831.
- Vertical regions: visible v 0..479; front porch 480..488; sync 489..491; back porch 492..519.
- All outputs are registered, decoded from next-state counter values, so every output in cycle t corresponds exactly to (h_cnt, v_cnt) in cycle t with no glitches.
- hsync=0 iff h in 664..727. vsync=0 iff v in 489..491, for the whole line including the horizontal blank.
- display_on=1 iff h<640 and v<480.
- x=h_cnt and y=v_cnt at all times, including blanking.
- The pipeline is responsible for forcing rgb to 0 when display_on=0.
- Reset values (asynchronous, while reset=0):
  - h_cnt=0, v_cnt=480, so the first frame begins at vertical front porch.
  - hsync=1, vsync=1, display_on=0, x=0, y=480, line_start=0, frame_start=0, frame_count=0, all scroll offsets 0.
- First rising edge after reset deasserts: counters advance to h=1, v=480. No line_start or frame_start pulse is issued for the reset-state position.
- Scroll scheduler, evaluated on the cycle frame_start is asserted:
  - If freeze=0: offset[i] <= offset[i] + (i+1), modulo 2^SCROLL_W; frame_count <= frame_count+1, wrapping 0xFFFF->0.
  - If freeze=1: nothing changes.
- freeze is sampled only on the frame_start cycle. Toggling it mid-frame has no effect until the next frame boundary.
- Offsets are stable for the whole visible region, so layers never tear.
- Reset asserted mid-line or mid-sync immediately returns every output to its reset values. There are no partial pulses after release.

Optional Feature:
- Macro: VGA_SCROLL_EN.
- Defined: the scroll scheduler and frame_count logic are present as described above.
- Undefined:
  - scroll_offsets is tied to 0 and frame_count is tied to 0.
  - freeze is ignored.
  - Timing outputs are bit-identical to the defined build.

Test Plan:
- Reset held low for 50 clocks, then released -> during reset hsync=1, vsync=1, display_on=0, y=480; first hsync falling edge occurs 664 clocks after release.
- Free-run one line -> hsync low for exactly 64 consecutive clocks; line_start pulses have an 832-clock period.
- Free-run one frame from release -> 9 hsync pulses before vsync falls; vsync low for exactly 3 line periods (2496 clocks); 28 more lines; then 480 lines containing display_on.
- Count display_on cycles over one full frame -> exactly 307200; frame_start period exactly 432640 clocks.
- Run 3 frame_start events with freeze=0, then 2 with freeze=1 -> frame_count=3; offsets = 3, 6, 9, 12 and unchanged after the frozen frames. Run 342 more unfrozen frames (frame_count=345) -> offset[3] = 345*4 mod 1024 = 356 (wrap check).
- Assert reset at h=700, v=490 (inside both syncs) -> hsync and vsync return to 1 asynchronously within the same cycle; after release the sequence restarts exactly as in the first scenario.
